// File: rtl/l2_cache_plru_victim_select.sv
// L2 cache replacement state: per-set 4-way tree pseudo-LRU array with
// hit/fill touch updates and a one-cycle-latency victim selector that
// prefers invalid ways. A power-up sweep clears every set before use.
module l2_cache_plru_victim_select #(
  parameter int INDEX_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   ready,
  input  logic                   lookup_valid,
  input  logic [INDEX_WIDTH-1:0] lookup_index,
  input  logic [3:0]             lookup_way_valid,
  output logic                   victim_valid,
  output logic [1:0]             victim_way,
  output logic                   victim_is_invalid,
  input  logic                   touch_valid,
  input  logic [INDEX_WIDTH-1:0] touch_index,
  input  logic [1:0]             touch_way
);

  localparam int NUM_SETS = 2 ** INDEX_WIDTH;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] sweep_cnt;
  logic [2:0]             lru_mem [NUM_SETS];

  logic       touch_en;
  logic       lookup_en;
  logic [2:0] lookup_lru;
  logic [1:0] sel_way;
  logic       sel_inv;

  // Tree update: bit 0 points away from the touched half, bit 1/2 away
  // from the touched way inside that half.
  function automatic logic [2:0] apply_touch(input logic [2:0] lru,
                                             input logic [1:0] way);
    logic [2:0] nxt;
    nxt = lru;
    case (way)
      2'd0: begin nxt[0] = 1'b0; nxt[1] = 1'b0; end
      2'd1: begin nxt[0] = 1'b0; nxt[1] = 1'b1; end
      2'd2: begin nxt[0] = 1'b1; nxt[2] = 1'b0; end
      default: begin nxt[0] = 1'b1; nxt[2] = 1'b1; end
    endcase
    return nxt;
  endfunction

  // Follow the tree bits to the least recently used leaf.
  function automatic logic [1:0] plru_victim(input logic [2:0] lru);
    if (lru[0]) return lru[1] ? 2'd0 : 2'd1;
    else        return lru[2] ? 2'd2 : 2'd3;
  endfunction

  assign touch_en  = touch_valid  && ready;
  assign lookup_en = lookup_valid && ready;

  // Victim choice with write-first forwarding of a same-set touch.
  // NOTE: every variable gets a default at the top so no latch is inferred.
  always_comb begin
    lookup_lru = lru_mem[lookup_index];
    if (touch_en && (touch_index == lookup_index))
      lookup_lru = apply_touch(lookup_lru, touch_way);
    sel_way = plru_victim(lookup_lru);
    sel_inv = 1'b1;
    if      (!lookup_way_valid[0]) sel_way = 2'd0;
    else if (!lookup_way_valid[1]) sel_way = 2'd1;
    else if (!lookup_way_valid[2]) sel_way = 2'd2;
    else if (!lookup_way_valid[3]) sel_way = 2'd3;
    else                           sel_inv = 1'b0;
  end

  // Init sweep FSM: clear one set per cycle, then raise ready.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (sweep_cnt == INDEX_WIDTH'(NUM_SETS - 1)) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  // PLRU array writes: sweep clears during INIT, touches update in RUN.
  // NOTE: the array is not reset directly; the sweep clears it, keeping it a plain RAM.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_INIT)
        lru_mem[sweep_cnt] <= 3'b000;
      else if (touch_en)
        lru_mem[touch_index] <= apply_touch(lru_mem[touch_index], touch_way);
    end
  end

  // Registered victim response, one cycle after an accepted lookup.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      victim_valid      <= 1'b0;
      victim_way        <= 2'd0;
      victim_is_invalid <= 1'b0;
    end else begin
      victim_valid <= lookup_en;
      if (lookup_en) begin
        victim_way        <= sel_way;
        victim_is_invalid <= sel_inv;
      end
    end
  end

endmodule

// File: tb/tb_l2_cache_plru_victim_select.sv
// Scoreboard bench for l2_cache_plru_victim_select: stimulus pushes the
// hand-computed victim for each accepted lookup, a monitor pops and compares
// on every victim_valid pulse.
module tb_l2_cache_plru_victim_select;

  localparam int INDEX_WIDTH = 3;
  localparam int NUM_SETS    = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   ready;
  logic                   lookup_valid;
  logic [INDEX_WIDTH-1:0] lookup_index;
  logic [3:0]             lookup_way_valid;
  logic                   victim_valid;
  logic [1:0]             victim_way;
  logic                   victim_is_invalid;
  logic                   touch_valid;
  logic [INDEX_WIDTH-1:0] touch_index;
  logic [1:0]             touch_way;

  typedef struct packed {
    logic [1:0] way;
    logic       inv;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  l2_cache_plru_victim_select #(.INDEX_WIDTH(INDEX_WIDTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ready             (ready),
    .lookup_valid      (lookup_valid),
    .lookup_index      (lookup_index),
    .lookup_way_valid  (lookup_way_valid),
    .victim_valid      (victim_valid),
    .victim_way        (victim_way),
    .victim_is_invalid (victim_is_invalid),
    .touch_valid       (touch_valid),
    .touch_index       (touch_index),
    .touch_way         (touch_way)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every victim pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (victim_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_victim_valid", 32'(victim_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("victim_way", 32'(victim_way), 32'(e.way));
          check("victim_is_invalid", 32'(victim_is_invalid), 32'(e.inv));
        end
      end
    end
  end

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_valid = 1'b0;
    touch_valid  = 1'b0;
  endtask

  // Present a lookup for one cycle and queue its expected victim.
  task automatic lookup(input logic [2:0] idx, input logic [3:0] wv,
                        input logic [1:0] ew, input logic ei);
    exp_t e;
    lookup_valid     = 1'b1;
    lookup_index     = idx;
    lookup_way_valid = wv;
    e.way = ew;
    e.inv = ei;
    exp_q.push_back(e);
  endtask

  task automatic touch(input logic [2:0] idx, input logic [1:0] way);
    touch_valid = 1'b1;
    touch_index = idx;
    touch_way   = way;
  endtask

  // Release reset and walk the sweep, with an ignored lookup pending.
  task automatic release_and_sweep();
    rst_n = 1'b1;
    lookup_valid     = 1'b1;
    lookup_index     = 3'd5;
    lookup_way_valid = 4'b1111;
    check("ready_at_release", 32'(ready), 32'd0);
    for (int i = 1; i <= NUM_SETS; i++) begin
      step();
      check($sformatf("ready_sweep_%0d", i), 32'(ready), (i == NUM_SETS) ? 32'd1 : 32'd0);
    end
    idle();
  endtask

  initial begin
    rst_n            = 1'b0;
    lookup_valid     = 1'b0;
    lookup_index     = '0;
    lookup_way_valid = 4'hf;
    touch_valid      = 1'b0;
    touch_index      = '0;
    touch_way        = '0;

    // 1. reset for two cycles, then the sweep
    step();
    step();
    check("ready_in_reset", 32'(ready), 32'd0);
    check("victim_valid_in_reset", 32'(victim_valid), 32'd0);
    release_and_sweep();
    step();

    // 2. untouched set, all valid -> way3
    lookup(3'd5, 4'b1111, 2'd3, 1'b0); step(); idle(); step();

    // 3. touch way3 -> 101 -> way1; touch way1 -> 110 -> way2
    touch(3'd5, 2'd3); step(); idle();
    lookup(3'd5, 4'b1111, 2'd1, 1'b0); step(); idle();
    touch(3'd5, 2'd1); step(); idle();
    lookup(3'd5, 4'b1111, 2'd2, 1'b0); step(); idle(); step();

    // 4. invalid-way preference, array untouched by lookup
    lookup(3'd1, 4'b1011, 2'd2, 1'b1); step(); idle();
    lookup(3'd1, 4'b1111, 2'd3, 1'b0); step(); idle();
    lookup(3'd1, 4'b0000, 2'd0, 1'b1); step(); idle(); step();

    // 5. same-cycle forwarding, then back-to-back lookups
    touch(3'd2, 2'd2);
    lookup(3'd2, 4'b1111, 2'd1, 1'b0); step(); idle();
    lookup(3'd2, 4'b1111, 2'd1, 1'b0); step();
    lookup(3'd0, 4'b1111, 2'd3, 1'b0); step(); idle(); step();

    // 6. touch, then lookup in the same cycle as reset: dropped
    touch(3'd5, 2'd0); step(); idle();
    rst_n            = 1'b0;
    lookup_valid     = 1'b1;
    lookup_index     = 3'd5;
    lookup_way_valid = 4'b1111;
    step();
    idle();
    check("ready_after_reset", 32'(ready), 32'd0);
    check("victim_valid_after_reset", 32'(victim_valid), 32'd0);
    step();
    release_and_sweep();
    lookup(3'd5, 4'b1111, 2'd3, 1'b0); step(); idle();

    // drain: every queued expectation must have been consumed
    for (int i = 0; i < 4; i++) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_cache_plru_victim_select.md
Name: l2_cache_plru_victim_select

Overview:
Per-set 4-way tree pseudo-LRU state store and victim selector for the L2 cache. It is the replacement side of the hit-update logic: it owns the 3-bit PLRU array and applies hit/fill touches using the team's tree encoding. On a miss lookup it returns the way to evict one cycle later, preferring invalid ways. It sits beside the L2 tag/data arrays and is driven by the L2 controller FSM.

Parameters:
INDEX_WIDTH, 3, set index width; NUM_SETS = 2**INDEX_WIDTH sets (8 by default).

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
ready  output  1  high once the init sweep completes; lookups and touches are ignored while low
lookup_valid  input  1  victim request; accepted when lookup_valid && ready
lookup_index  input  INDEX_WIDTH  set index of the request
lookup_way_valid  input  4  valid bits of ways 3..0 of that set, sampled at acceptance
victim_valid  output  1  one-cycle pulse one cycle after an accepted lookup
victim_way  output  2  selected way; held until the next victim_valid pulse
victim_is_invalid  output  1  selected way was invalid (no writeback/eviction needed)
touch_valid  input  1  hit or fill update, applied when ready
touch_index  input  INDEX_WIDTH  set to update
touch_way  input  2  way just used

Behaviour:
- Tree encoding, lru[2:0] per set. Touch way0: lru[0]=0, lru[1]=0. Touch way1: lru[0]=0, lru[1]=1. Touch way2: lru[0]=1, lru[2]=0. Touch way3: lru[0]=1, lru[2]=1. Bits not listed are unchanged.
- PLRU victim: if lru[0]=1, victim = lru[1] ? way0 : way1. If lru[0]=0, victim = lru[2] ? way2 : way3.
- Selection: if any lookup_way_valid bit is 0, victim_way is the lowest-index invalid way and victim_is_invalid=1. Otherwise victim_way is the PLRU victim and victim_is_invalid=0.
- Lookups never modify the array. Only touches modify it.
- FSM states:
  - INIT: a sweep counter writes 3'b000 to sets 0..NUM_SETS-1, one set per cycle. ready=0. Touches and lookups are ignored.
  - RUN: entered after the last set is written. ready=1.
- Reset (rst_n=0 at a clock edge):
  - state=INIT, counter=0.
  - ready=0, victim_valid=0, victim_way=0, victim_is_invalid=0.
  - Any pending victim response is dropped.
  - After rst_n returns high, the sweep takes exactly NUM_SETS cycles; ready rises on the edge following the write of set NUM_SETS-1.
- Latency: lookup accepted at edge N, so victim_valid=1 and victim_way are valid in the cycle after edge N. Back-to-back lookups are accepted every cycle. victim_valid deasserts when there is no lookup.
- Same-cycle touch and lookup to the same index: the lookup sees the post-touch state (write-first forwarding). Different indices are independent.
- Touch and lookup in the same cycle as reset: ignored.
- Index is unsigned. All NUM_SETS entries are reachable; there is no wrap beyond NUM_SETS-1.

Test Plan:
1. Reset/init: hold rst_n=0 for 2 cycles, then release. Required: ready=0 for 8 cycles, then 1; victim_valid stays 0 throughout; a lookup issued during INIT produces no victim_valid.
2. After init, lookup idx5 with way_valid=4'b1111. Required: next cycle victim_valid=1, victim_way=3, victim_is_invalid=0.
3. Touch idx5 way3 (lru becomes 3'b101), then lookup idx5 → victim_way=1. Then touch idx5 way1 (lru becomes 3'b110), then lookup → victim_way=2.
4. Lookup idx1 with way_valid=4'b1011. Required: victim_way=2, victim_is_invalid=1, and idx1 lru still 3'b000 (a following all-valid lookup returns way3).
5. Same cycle: touch idx2 way2 plus lookup idx2 with all ways valid. Required: victim_way=1 (forwarded 3'b001, not the stale way3). Then back-to-back lookups idx2, idx0 → victim_way 1 then 3 on consecutive cycles.
6. Touch idx5 way0, accept a lookup, then assert rst_n=0 on the next edge. Required: no victim_valid pulse, ready=0. After the re-sweep, a lookup on idx5 returns way3 (state cleared).
